// File: rtl/cfg_bank_pkg.sv
// Shared types and defaults for the encrypt/decrypt configuration bank.
package cfg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IDLE = 2'd1,
        COPY      = 2'd2,
        ACK       = 2'd3
    } cfg_state_t;

    localparam int CFG_DATA_W_DEF   = 64;
    localparam int CFG_NUM_REGS_DEF = 4;

    // Register index width; a single-register bank still gets a 1-bit address.
    function automatic int cfg_addr_w(input int num_regs);
        return (num_regs > 2) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/config_reg_bank_if.sv
// Host write / commit bus and downstream config view of the configuration bank.
interface config_reg_bank_if
    import cfg_bank_pkg::*;
#(
    parameter int DATA_W   = CFG_DATA_W_DEF,
    parameter int NUM_REGS = CFG_NUM_REGS_DEF,
    parameter int ADDR_W   = cfg_addr_w(NUM_REGS)
) ();

    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic [DATA_W/8-1:0]        wr_strb;
    logic                       wr_ready;
    logic                       wr_err;
    logic                       commit_req;
    logic                       lock_req;
    logic                       engine_busy;
    logic                       commit_ack;
    logic                       cfg_valid;
    logic                       locked;
    logic [NUM_REGS*DATA_W-1:0] cfg_out;

    modport master (
        output wr_en, wr_addr, wr_data, wr_strb, commit_req, lock_req, engine_busy,
        input  wr_ready, wr_err, commit_ack, cfg_valid, locked, cfg_out
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_strb, commit_req, lock_req, engine_busy,
        output wr_ready, wr_err, commit_ack, cfg_valid, locked, cfg_out
    );

endinterface

// File: rtl/cfg_strobe_reg.sv
// One DATA_W register whose bytes load independently under a per-byte enable.
module cfg_strobe_reg
    import cfg_bank_pkg::*;
#(
    parameter int DATA_W = CFG_DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W/8-1:0] en_strb,
    input  logic [DATA_W-1:0]   d,
    output logic [DATA_W-1:0]   q
);

    localparam int NB = DATA_W / 8;

    // Load enabled byte lanes, hold the rest; async clear to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            for (int k = 0; k < NB; k++) begin
                if (en_strb[k]) q[k*8 +: 8] <= d[k*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/config_reg_bank.sv
// Shadow/active configuration bank: the host fills the shadow with byte-strobed
// writes, and a commit copies it to the active bank only while the engine is idle.
module config_reg_bank
    import cfg_bank_pkg::*;
#(
    parameter int DATA_W   = CFG_DATA_W_DEF,
    parameter int NUM_REGS = CFG_NUM_REGS_DEF,
    parameter int ADDR_W   = cfg_addr_w(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    config_reg_bank_if.slave  bus
);

    localparam int NB = DATA_W / 8;

    cfg_state_t state, state_nx;

    logic [ADDR_W-1:0]                 addr;
    logic                              wr_acc;
    logic                              addr_bad;
    logic                              wr_ok;
    logic                              copy_en;
    logic                              wr_err_q;
    logic                              locked_q;
    logic                              cfg_valid_q;
    logic [NUM_REGS-1:0][DATA_W-1:0]   active;

    assign addr     = bus.wr_addr;
    // Writes are only taken while no commit is in flight, so the shadow is
    // stable for the whole WAIT_IDLE/COPY window.
    assign wr_acc   = bus.wr_en && (state == IDLE);
    assign addr_bad = (int'(addr) >= NUM_REGS);
    assign wr_ok    = wr_acc && !addr_bad && !locked_q;
    assign copy_en  = (state == COPY);

    // Commit FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Commit sequencing: wait for an idle engine, copy, then acknowledge.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (bus.commit_req)   state_nx = WAIT_IDLE;
            WAIT_IDLE: if (!bus.engine_busy) state_nx = COPY;
            COPY:                            state_nx = ACK;
            ACK:                             state_nx = IDLE;
            default:                         state_nx = IDLE;
        endcase
    end

    // Rejected-write pulse, sticky lock and sticky first-commit flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_err_q    <= 1'b0;
            locked_q    <= 1'b0;
            cfg_valid_q <= 1'b0;
        end else begin
            wr_err_q <= wr_acc && (addr_bad || locked_q);
            if (bus.lock_req)  locked_q    <= 1'b1;
            if (state == ACK)  cfg_valid_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic [NB-1:0]     sh_strb;
        logic [DATA_W-1:0] sh_q;
        logic [DATA_W-1:0] act_q;

        assign sh_strb = (wr_ok && (int'(addr) == i)) ? bus.wr_strb : '0;

        cfg_strobe_reg #(.DATA_W(DATA_W)) u_shadow (
            .clk     (clk),
            .rst     (rst),
            .en_strb (sh_strb),
            .d       (bus.wr_data),
            .q       (sh_q)
        );

        cfg_strobe_reg #(.DATA_W(DATA_W)) u_active (
            .clk     (clk),
            .rst     (rst),
            .en_strb ({NB{copy_en}}),
            .d       (sh_q),
            .q       (act_q)
        );

        assign active[i] = act_q;
    end

    assign bus.wr_ready   = (state == IDLE);
    assign bus.commit_ack = (state == ACK);
    assign bus.wr_err     = wr_err_q;
    assign bus.locked     = locked_q;
    assign bus.cfg_valid  = cfg_valid_q;
    assign bus.cfg_out    = active;

endmodule

// File: tb/tb_config_reg_bank.sv
// Self-checking bench for config_reg_bank: a transaction-level model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_config_reg_bank;
    import cfg_bank_pkg::*;

    localparam int DW = 64;
    localparam int NR = 4;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    config_reg_bank_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) bus ();
    config_reg_bank_if #(.DATA_W(DW), .NUM_REGS(3),  .ADDR_W(2))  bus3 ();

    config_reg_bank #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    config_reg_bank #(.DATA_W(DW), .NUM_REGS(3), .ADDR_W(2)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m_free: bank open to writes; m_wait: commit waiting on engine;
    // m_copy: copy happens at next edge; m_ack: ack visible now.
    logic [DW-1:0] m_sh  [NR];
    logic [DW-1:0] m_act [NR];
    bit m_free, m_wait, m_copy, m_ack, m_valid, m_locked, m_err;

    task automatic m_reset();
        for (int i = 0; i < NR; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
        m_free = 1; m_wait = 0; m_copy = 0; m_ack = 0;
        m_valid = 0; m_locked = 0; m_err = 0;
    endtask

    // Predict visible state after the coming rising edge from current inputs.
    task automatic m_advance();
        bit nerr;
        int a;
        nerr = 0;
        a = int'(bus.wr_addr);
        if (m_free) begin
            if (bus.wr_en) begin
                if (a >= NR || m_locked) nerr = 1;
                else
                    for (int k = 0; k < DW/8; k++)
                        if (bus.wr_strb[k]) m_sh[a][k*8 +: 8] = bus.wr_data[k*8 +: 8];
            end
            if (bus.commit_req) begin m_free = 0; m_wait = 1; end
        end else if (m_wait) begin
            if (!bus.engine_busy) begin m_wait = 0; m_copy = 1; end
        end else if (m_copy) begin
            m_copy = 0;
            for (int i = 0; i < NR; i++) m_act[i] = m_sh[i];
            m_ack = 1;
        end else if (m_ack) begin
            m_ack = 0; m_valid = 1; m_free = 1;
        end
        if (bus.lock_req) m_locked = 1;
        m_err = nerr;
    endtask

    // Compare DUT to model at every falling edge, then step the model.
    always @(negedge clk) begin
        logic [255:0] exp_out;
        if (!rst) m_reset();
        if (mon_en) begin
            exp_out = '0;
            for (int i = 0; i < NR; i++) exp_out[i*DW +: DW] = m_act[i];
            chk("mon_wr_ready",   bus.wr_ready,   m_free);
            chk("mon_wr_err",     bus.wr_err,     m_err);
            chk("mon_commit_ack", bus.commit_ack, m_ack);
            chk("mon_cfg_valid",  bus.cfg_valid,  m_valid);
            chk("mon_locked",     bus.locked,     m_locked);
            chk("mon_cfg_out",    bus.cfg_out,    exp_out);
        end
        if (rst) m_advance();
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [63:0] d, input logic [7:0] s);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a[AW-1:0];
        bus.wr_data = d;
        bus.wr_strb = s;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // Pulse commit_req for one edge; lat = edges until commit_ack is seen.
    task automatic do_commit(output int lat);
        bus.commit_req = 1'b1;
        lat = 0;
        do begin
            tick();
            bus.commit_req = 1'b0;
            lat++;
        end while (!bus.commit_ack && lat < 40);
        if (!bus.commit_ack) chk("commit_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] held;
        int lat;
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_strb = '0;
        bus.commit_req = 0; bus.lock_req = 0; bus.engine_busy = 0;
        bus3.wr_en = 0; bus3.wr_addr = '0; bus3.wr_data = '0; bus3.wr_strb = '0;
        bus3.commit_req = 0; bus3.lock_req = 0; bus3.engine_busy = 0;
        m_reset();
        repeat (2) tick();
        rst = 1'b1;
        mon_en = 1'b1;
        tick();

        // reset state
        chk("rst_cfg_out",  bus.cfg_out,   256'h0);
        chk("rst_valid",    bus.cfg_valid, 1'b0);
        chk("rst_ready",    bus.wr_ready,  1'b1);
        chk("rst_locked",   bus.locked,    1'b0);

        // T2: full write then commit, 3-edge latency
        wr(2, 64'hDEAD_BEEF_0123_4567, 8'hFF);
        do_commit(lat);
        chk("t2_latency", lat, 3);
        chk("t2_reg2",    bus.cfg_out[191:128], 64'hDEAD_BEEF_0123_4567);
        tick();
        chk("t2_ack_pulse", bus.commit_ack, 1'b0);
        chk("t2_valid",     bus.cfg_valid,  1'b1);

        // T3: strobe merge on reg0
        wr(0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        wr(0, 64'h0, 8'h0F);
        wr(3, 64'h1234_5678_9ABC_DEF0, 8'h00);
        do_commit(lat);
        chk("t3_reg0", bus.cfg_out[63:0],    64'hFFFF_FFFF_0000_0000);
        chk("t3_reg3_nostrb", bus.cfg_out[255:192], 64'h0);
        tick();

        // write and commit in the same IDLE cycle
        bus.wr_en = 1; bus.wr_addr = 2'd1; bus.wr_data = 64'h0000_1111_2222_3333; bus.wr_strb = 8'hF0;
        do_commit(lat);
        chk("same_cycle_lat",  lat, 3);
        chk("same_cycle_reg1", bus.cfg_out[127:64], 64'h0000_1111_0000_0000);
        tick();

        // T4: commit held off by a busy engine; writes and commit_req ignored meanwhile
        bus.engine_busy = 1'b1;
        held = bus.cfg_out;
        wr(3, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);   // shadow reg3 will be copied
        bus.commit_req = 1'b1;
        tick();
        bus.commit_req = 1'b0;
        bus.wr_en = 1; bus.wr_addr = 2'd0; bus.wr_data = 64'h5555; bus.wr_strb = 8'hFF;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) bus.commit_req = 1'b1;
            if (c == 5) bus.commit_req = 1'b0;
            tick();
            chk("t4_no_ack",    bus.commit_ack, 1'b0);
            chk("t4_not_ready", bus.wr_ready,   1'b0);
            chk("t4_held_out",  bus.cfg_out,    held);
        end
        bus.wr_en = 1'b0;
        bus.engine_busy = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (!bus.commit_ack && lat < 40);
        chk("t4_release_lat", lat, 2);
        chk("t4_reg3", bus.cfg_out[255:192], 64'hAAAA_AAAA_AAAA_AAAA);
        chk("t4_reg0", bus.cfg_out[63:0],    64'hFFFF_FFFF_0000_0000);
        tick();

        // T5: write after lock is rejected, commit still legal
        bus.lock_req = 1'b1;
        tick();
        bus.lock_req = 1'b0;
        chk("t5_locked", bus.locked, 1'b1);
        wr(2, 64'h0, 8'hFF);
        chk("t5_lock_err", bus.wr_err, 1'b1);
        tick();
        chk("t5_lock_err_end", bus.wr_err, 1'b0);
        do_commit(lat);
        chk("t5_locked_lat", lat, 3);
        chk("t5_reg2_kept", bus.cfg_out[191:128], 64'hDEAD_BEEF_0123_4567);
        tick();

        // T5: out-of-range address on the 3-register bank
        bus3.wr_en = 1; bus3.wr_addr = 2'd3; bus3.wr_data = '1; bus3.wr_strb = 8'hFF;
        tick();
        bus3.wr_en = 1'b0;
        chk("t5_addr_err", bus3.wr_err, 1'b1);
        tick();
        chk("t5_addr_err_end", bus3.wr_err, 1'b0);
        bus3.wr_en = 1; bus3.wr_addr = 2'd2; bus3.wr_data = 64'h5; bus3.wr_strb = 8'h01;
        bus3.commit_req = 1'b1;
        tick();
        bus3.wr_en = 1'b0; bus3.commit_req = 1'b0;
        lat = 1;
        while (!bus3.commit_ack && lat < 40) begin tick(); lat++; end
        chk("t5_r3_lat", lat, 3);
        chk("t5_r3_out", bus3.cfg_out, 192'h5 << 128);

        // T6 + mid-stream reset: rst asserted while in COPY
        tick();
        bus.commit_req = 1'b1;
        tick();
        bus.commit_req = 1'b0;
        tick();                 // now in COPY
        rst = 1'b0;
        #1;
        chk("t6_out_clr",  bus.cfg_out,   256'h0);
        chk("t6_ready",    bus.wr_ready,  1'b1);
        chk("t6_valid",    bus.cfg_valid, 1'b0);
        chk("t6_locked",   bus.locked,    1'b0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t6_no_ack", bus.commit_ack, 1'b0);
            chk("t6_out_zero", bus.cfg_out,  256'h0);
        end

        mon_en = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
